// File: rtl/srio_swrite_pack_logic.sv
// Packs TDEST-tagged AXIS payload into SRIO SWRITE segments (HELLO header + up to MAX_BEATS beats).
// Latency: header valid 1 cycle after the closing input beat; 1 beat/cycle inside a segment.
// Backpressure: S_AXIS_TREADY drops while no segment buffer is free; the output holds under M_AXIS_TREADY=0.
// Optional SRIO_PACK_PINGPONG_EN: two segment buffers so filling overlaps header/payload emission.
module srio_swrite_pack_logic #(
    parameter int MAX_BEATS = 32,
    parameter int BUF_AW    = 5
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESET,
    input  logic [63:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic        S_AXIS_TLAST,
    input  logic [3:0]  S_AXIS_TDEST,
    output logic [63:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic        M_AXIS_TLAST,
    input  logic [31:0] cmd,
    input  logic [31:0] addr_0,
    input  logic [31:0] addr_1,
    output logic [31:0] drop_count
);

`ifdef SRIO_PACK_PINGPONG_EN
    localparam int   NBUF     = 2;
    localparam logic BUF_STEP = 1'b1;
`else
    localparam int   NBUF     = 1;
    localparam logic BUF_STEP = 1'b0;
`endif
    localparam int LW = BUF_AW + 1;

    typedef enum logic [1:0] {IDLE, FILL, DROP} in_state_t;
    typedef enum logic {HDR, SEND} out_state_t;

    in_state_t  in_q, in_d;
    out_state_t out_q, out_d;

    logic            mid_pkt;
    logic [LW-1:0]   wr_level;
    logic            wr_buf, rd_buf;
    logic [NBUF-1:0] seg_full;
    logic [LW-1:0]   seg_len  [NBUF];
    logic [31:0]     seg_addr [NBUF];
    logic [63:0]     mem      [NBUF][2**BUF_AW];
    logic [31:0]     cur_addr;
    logic [LW-1:0]   rd_cnt;
    logic [7:0]      tid;
    logic [31:0]     drop_cnt_q;

    logic            soft_rst, first_beat, bad_dest;
    logic            in_fire, fill_fire, drop_fire, seg_close;
    logic            out_fire, last_fire;
    logic [31:0]     eff_addr;
    logic [LW+2:0]   seg_bytes;
    logic [63:0]     hdr_dat;
    logic            cmd_unused;

    assign cmd_unused = ^{cmd[31:6], cmd[3:2]};
    assign soft_rst   = cmd[1];
    assign drop_count = drop_cnt_q;

    always_comb begin
        first_beat    = !mid_pkt;
        bad_dest      = S_AXIS_TDEST > 4'd1;
        // A new packet is only started while enabled; a split packet always finishes.
        S_AXIS_TREADY = !soft_rst &&
                        ((in_q == FILL && !seg_full[wr_buf] && (mid_pkt || cmd[0])) || in_q == DROP);
        in_fire       = S_AXIS_TVALID && S_AXIS_TREADY;
        drop_fire     = in_fire && in_q == FILL && first_beat && bad_dest;
        fill_fire     = in_fire && in_q == FILL && !drop_fire;
        seg_close     = fill_fire && (S_AXIS_TLAST || wr_level == LW'(MAX_BEATS - 1));
        eff_addr      = first_beat ? (S_AXIS_TDEST[0] ? addr_1 : addr_0) : cur_addr;

        in_d = in_q;
        case (in_q)
            IDLE: if (cmd[0]) in_d = mid_pkt ? DROP : FILL;
            FILL: begin
                if (drop_fire && !S_AXIS_TLAST) in_d = DROP;
                else if (!mid_pkt && !cmd[0])   in_d = IDLE;
            end
            DROP:    if (in_fire && S_AXIS_TLAST) in_d = cmd[0] ? FILL : IDLE;
            default: in_d = IDLE;
        endcase
        if (soft_rst) in_d = IDLE;
    end

    always_comb begin
        seg_bytes     = {seg_len[rd_buf], 3'b000} - (LW + 3)'(1);
        hdr_dat       = {tid, 4'h6, 4'h0, 1'b0, cmd[5:4], 1'b0, 8'(seg_bytes), 4'h0, seg_addr[rd_buf]};
        M_AXIS_TVALID = !soft_rst && ((out_q == HDR && seg_full[rd_buf]) || out_q == SEND);
        M_AXIS_TLAST  = (out_q == SEND) && (rd_cnt == seg_len[rd_buf] - LW'(1));
        if (out_q == SEND)         M_AXIS_TDATA = mem[rd_buf][rd_cnt[BUF_AW-1:0]];
        else if (seg_full[rd_buf]) M_AXIS_TDATA = hdr_dat;
        else                       M_AXIS_TDATA = '0;
        out_fire  = M_AXIS_TVALID && M_AXIS_TREADY;
        last_fire = out_fire && M_AXIS_TLAST;

        out_d = out_q;
        if (out_q == HDR) begin
            if (out_fire) out_d = SEND;
        end else if (last_fire) begin
            out_d = HDR;
        end
        if (soft_rst) out_d = HDR;
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (fill_fire) begin
            mem[wr_buf][wr_level[BUF_AW-1:0]] <= S_AXIS_TDATA;
            if (wr_level == '0) seg_addr[wr_buf] <= eff_addr;
        end
        if (seg_close) seg_len[wr_buf] <= wr_level + LW'(1);
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            in_q       <= IDLE;
            out_q      <= HDR;
            mid_pkt    <= 1'b0;
            wr_level   <= '0;
            wr_buf     <= 1'b0;
            rd_buf     <= 1'b0;
            seg_full   <= '0;
            rd_cnt     <= '0;
            tid        <= '0;
            drop_cnt_q <= '0;
            cur_addr   <= '0;
        end else begin
            in_q  <= in_d;
            out_q <= out_d;
            if (in_fire)   mid_pkt    <= !S_AXIS_TLAST;
            if (drop_fire) drop_cnt_q <= drop_cnt_q + 32'd1;
            // Next segment of a split packet continues right after this one.
            if (fill_fire && wr_level == '0) cur_addr <= eff_addr + 32'(MAX_BEATS * 8);
            if (out_fire && out_q == HDR) begin
                tid    <= tid + 8'd1;
                rd_cnt <= '0;
            end
            if (out_fire && out_q == SEND) rd_cnt <= rd_cnt + LW'(1);
            if (last_fire) begin
                seg_full[rd_buf] <= 1'b0;
                rd_buf           <= rd_buf ^ BUF_STEP;
            end
            if (seg_close) begin
                seg_full[wr_buf] <= 1'b1;
                wr_buf           <= wr_buf ^ BUF_STEP;
                wr_level         <= '0;
            end else if (fill_fire) begin
                wr_level <= wr_level + LW'(1);
            end
            if (soft_rst) begin
                seg_full <= '0;
                wr_buf   <= 1'b0;
                rd_buf   <= 1'b0;
                wr_level <= '0;
            end
        end
    end

endmodule

// File: tb/tb_srio_swrite_pack_logic.sv
// Scoreboard bench for srio_swrite_pack_logic: randomized packets against a segment-level reference model.
module tb_srio_swrite_pack_logic;
    localparam int MAXB = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic [3:0]  s_tdest;
    logic [63:0] m_tdata;
    logic        m_tvalid, m_tlast;
    logic        m_tready = 1'b1;
    logic [31:0] cmd, addr_0, addr_1, drop_count;

    always #5 clk = ~clk;

    srio_swrite_pack_logic dut (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
        .S_AXIS_TLAST(s_tlast), .S_AXIS_TDEST(s_tdest),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
        .M_AXIS_TLAST(m_tlast),
        .cmd(cmd), .addr_0(addr_0), .addr_1(addr_1), .drop_count(drop_count)
    );

    typedef struct packed {logic [63:0] dat; logic last;} beat_t;
    beat_t       exp_q[$];
    logic [63:0] pkt_q[$];
    beat_t       mon_e;
    int          checks = 0, failures = 0;
    logic [7:0]  tid_m;
    int          exp_drops;
    int          tready_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: whole packet split into MAXB-beat segments, each a header then its beats.
    function automatic void model_pkt(input logic [3:0] dest);
        logic [31:0] a;
        int n;
        n = pkt_q.size();
        if (dest > 4'd1) begin
            exp_drops++;
            return;
        end
        a = (dest == 4'd0) ? addr_0 : addr_1;
        for (int off = 0; off < n; off += MAXB) begin
            int seg;
            logic [7:0] sz;
            seg = (n - off > MAXB) ? MAXB : n - off;
            sz  = 8'(seg * 8 - 1);
            exp_q.push_back('{dat: {tid_m, 4'h6, 4'h0, 1'b0, cmd[5:4], 1'b0, sz, 4'h0, a}, last: 1'b0});
            for (int k = 0; k < seg; k++) exp_q.push_back('{dat: pkt_q[off + k], last: (k == seg - 1)});
            tid_m++;
            a += 32'd256;
        end
    endfunction

    task automatic drive_beat(input logic [3:0] dest, input logic [63:0] d, input logic last);
        int n;
        bit done;
        n = 0;
        done = 0;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
        s_tvalid = 1'b1; s_tdata = d; s_tlast = last; s_tdest = dest;
        while (!done) begin
            @(negedge clk);
            done = (s_tready === 1'b1);
            @(posedge clk); #1;
            n++;
            if (!done && n > 5000) begin
                checks++; failures++;
                $display("FAIL input_accept_timeout actual=no_tready required=tready_within_5000");
                break;
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] dest, input int n);
        pkt_q.delete();
        for (int i = 0; i < n; i++) pkt_q.push_back({$urandom, $urandom});
        model_pkt(dest);
        for (int i = 0; i < n; i++) drive_beat(dest, pkt_q[i], i == n - 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20000) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (tready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(0, 2) != 0);
            default: m_tready = ~m_tready;
        endcase
    end

    logic        stall_q = 1'b0;
    logic [63:0] held_d;
    logic        held_l;
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 64'(m_tvalid), 64'd1);
                chk("hold_data", m_tdata, held_d);
                chk("hold_last", 64'(m_tlast), 64'(held_l));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat actual=%h required=no_beat", m_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", m_tdata, mon_e.dat);
                    chk("out_last", 64'(m_tlast), 64'(mon_e.last));
                end
            end
            stall_q = m_tvalid && !m_tready;
            held_d  = m_tdata;
            held_l  = m_tlast;
        end
    end

    initial begin
        rst = 1'b1; cmd = 32'h0; addr_0 = 32'h1000_0000; addr_1 = 32'h2000_0000;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tdest = '0;
        tid_m = 8'h00; exp_drops = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tdata", m_tdata, 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cmd = 32'h1;

        // 4-beat packet: known header, header one cycle after the closing beat
        send_pkt(4'd0, 4);
        @(negedge clk);
        chk("hdr_latency_valid", 64'(m_tvalid), 64'd1);
        chk("hdr_first_value", m_tdata, 64'h0060_01F0_1000_0000);
        wait_drain();

        // 40-beat packet split into 32 + 8
        send_pkt(4'd1, 40);
        wait_drain();

        // unmapped TDEST dropped, next packet normal
        send_pkt(4'd3, 5);
        wait_drain();
        chk("drop_count_after_drop", 64'(drop_count), 64'(exp_drops));
        send_pkt(4'd0, 3);
        wait_drain();

        // output ready toggling 1-0-1
        tready_mode = 2;
        send_pkt(4'd0, 6);
        send_pkt(4'd1, 3);
        wait_drain();
        tready_mode = 0;

        // soft reset after 2 of 6 beats
        pkt_q.delete();
        for (int i = 0; i < 6; i++) pkt_q.push_back({$urandom, $urandom});
        for (int i = 0; i < 2; i++) drive_beat(4'd0, pkt_q[i], 1'b0);
        cmd = 32'h2;
        @(posedge clk); #1;
        cmd = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_tready_low", 64'(s_tready), 64'd0);
        chk("abort_no_valid", 64'(m_tvalid), 64'd0);
        @(posedge clk); #1;
        cmd = 32'h1;
        for (int i = 2; i < 6; i++) drive_beat(4'd0, pkt_q[i], i == 5);
        send_pkt(4'd0, 5);
        wait_drain();
        chk("drop_count_after_abort", 64'(drop_count), 64'(exp_drops));

        // randomized traffic with varying PRIO, addresses and output stalls
        tready_mode = 1;
        for (int r = 0; r < 3; r++) begin
            cmd    = 32'h1 | (32'($urandom_range(0, 3)) << 4);
            addr_0 = $urandom;
            addr_1 = $urandom;
            for (int p = 0; p < 12; p++) begin
                int sel, len;
                logic [3:0] d;
                sel = $urandom_range(0, 9);
                d   = (sel < 4) ? 4'd0 : (sel < 8) ? 4'd1 : 4'($urandom_range(2, 15));
                len = (p == 0) ? 32 : (p == 1) ? 33 : (p == 2) ? 64 : $urandom_range(1, 70);
                send_pkt(d, len);
            end
            wait_drain();
        end
        chk("drop_count_random", 64'(drop_count), 64'(exp_drops));
        tready_mode = 0;

        // reset again, then 257 single-beat packets to see the tid wrap
        cmd = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_drop_count", 64'(drop_count), 64'd0);
        @(posedge clk); #1;
        tid_m = 8'h00; exp_drops = 0;
        cmd = 32'h1;
        for (int p = 0; p < 257; p++) send_pkt(4'($urandom_range(0, 1)), 1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/srio_swrite_pack_logic.md
Name: srio_swrite_pack_logic

Overview:
- Upstream counterpart of the SWRITE unpacker: takes a 64-bit AXIS payload stream tagged with TDEST (ad9361 branch) and emits SRIO Ftype 6 (SWRITE) packets as one HELLO header beat followed by the payload.
- Each input packet is buffered up to MAX_BEATS beats so the header SIZE field is known before the header is sent.
- Input packets longer than MAX_BEATS are split into consecutive segments with advancing addresses.
- Sits between the DMA/VITA packer and the SRIO core user port.

Parameters:
- MAX_BEATS, 32, max payload beats per SWRITE segment (1..32; 32 beats = 256 bytes).
- BUF_AW, 5, buffer address width; 2^BUF_AW >= MAX_BEATS.

Ports:
- AXIS_ACLK  in  1  clock
- AXIS_ARESET  in  1  synchronous, active-high reset
- S_AXIS_TDATA  in  64  payload
- S_AXIS_TVALID  in  1  payload valid
- S_AXIS_TREADY  out  1  payload ready
- S_AXIS_TLAST  in  1  end of input packet
- S_AXIS_TDEST  in  4  branch select, sampled on first beat of packet
- M_AXIS_TDATA  out  64  header/payload to SRIO
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TREADY  in  1  output ready
- M_AXIS_TLAST  out  1  last beat of SWRITE segment
- cmd  in  32  [0] start, [1] soft reset, [5:4] PRIO
- addr_0  in  32  SRIO base address for TDEST 0
- addr_1  in  32  SRIO base address for TDEST 1
- drop_count  out  32  input packets discarded due to unmapped TDEST

Behaviour:
- Reset (AXIS_ARESET=1 at clock edge): state IDLE; S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, tid counter=0, drop_count=0, buffer level=0.
- cmd[1]=1 forces IDLE at the next edge from any state and discards buffered data. A partially accepted input packet is not resumed: the remaining input beats are dropped up to and including TLAST (DROP state). cmd[1] has priority over every other transition.
- States:
  - IDLE: TREADY=0; go to FILL when cmd[0]=1.
  - FILL: TREADY=1. Each accepted beat is written to the buffer and the level is incremented. On the first beat of a packet, TDEST is latched: TDEST 0 selects addr_0, TDEST 1 selects addr_1; any other value goes to DROP and increments drop_count. The segment closes when TLAST is accepted or the level reaches MAX_BEATS; go to HDR.
  - DROP: TREADY=1; discard beats until TLAST is accepted, then go to FILL (IDLE if cmd[0]=0).
  - HDR: TREADY=0. TVALID=1 on the cycle after the closing beat is accepted. Header fields:
    - [63:56] tid counter
    - [55:52] 4'h6
    - [51:48] 4'h0
    - [47] 0
    - [46:45] cmd[5:4]
    - [44] 0
    - [43:36] level*8-1 (8 bits)
    - [35:32] 0
    - [31:0] current segment address
  - On header transfer, tid increments (8-bit wrap, 8'hFF->8'h00); go to SEND.
  - SEND: TREADY=0. Emit buffered beats in order; TLAST on beat number level. After the last transfer, clear level.
    - If the segment was closed by input TLAST: go to FILL (IDLE if cmd[0]=0), address reloads from addr_x on the next packet.
    - If closed by MAX_BEATS: address += MAX_BEATS*8 (32-bit wrap), TDEST retained, return to FILL to continue the same input packet with no new TDEST sample.
- A MAX_BEATS-th beat that also carries TLAST closes as a TLAST segment; no empty segment is generated.
- TDATA/TLAST hold stable while TVALID=1 and TREADY=0.
- Latency: closing input beat -> header TVALID is 1 cycle. Throughput is 1 beat/cycle within a segment.
- cmd[0] deasserted mid-packet: the current input packet and its segments complete, then go to IDLE.

Optional Feature:
- SRIO_PACK_PINGPONG_EN
- Defined: two segment buffers. FILL into one buffer proceeds concurrently with HDR/SEND from the other, so S_AXIS_TREADY stays high unless both buffers are occupied. Segment order is preserved.
- Undefined: single buffer as above; S_AXIS_TREADY=0 throughout HDR/SEND.

Test Plan:
- cmd=1, TDEST=0, addr_0=0x1000_0000, 4-beat packet -> header 0x0060_01F0_1000_0000 with PRIO=0, SIZE=0x1F, tid=0; then 4 payload beats, TLAST on beat 4.
- TDEST=1, addr_1=0x2000_0000, 40-beat packet -> segment 1: SIZE=0xFF, addr 0x2000_0000, 32 beats; segment 2: tid=1, SIZE=0x3F, addr 0x2000_0100, 8 beats.
- TDEST=3 packet of 5 beats -> no output; drop_count 0->1; the next TDEST=0 packet passes normally.
- M_AXIS_TREADY toggled 1-0-1 during header and payload -> data held stable; no beats lost or duplicated.
- cmd[1] pulsed after 2 of 6 input beats accepted -> no output; IDLE; after cmd[0] is reasserted, the tail of the packet is dropped through TLAST and the next packet is output intact.
- 256 single-beat packets -> tid sequence 0x00..0xFF, then wraps to 0x00.
